// File: rtl/sha_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_uart_pkg
// Brief    : Shared widths and packer FSM encoding for the UART <-> SHA-256 path.
// Revision : 1.0 - initial release
// ============================================================================
package sha_uart_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_EMIT  = 1'b1
    } packer_state_t;

endpackage : sha_uart_pkg
`default_nettype wire

// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_packer
// Brief    : Drains UART RX FIFO bytes into MSB-first 32-bit words on a
//            valid/ready stream, tagging block ends and timing out stalls.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_packer
    import sha_uart_pkg::*;
#(
    parameter  int WORDS_PER_BLOCK = 16,
    parameter  int TIMEOUT_CYCLES  = 500000,
    localparam int C_IDX_W         = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_empty,
    input  logic [BYTE_W-1:0]  rx_data,
    output logic               rx_read,
    output logic [WORD_W-1:0]  word_data,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               word_last,
    output logic [C_IDX_W-1:0] word_idx,
    output logic               timeout_err,
    output logic               busy
);

    localparam int               C_TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(WORDS_PER_BLOCK - 1);

    packer_state_t      state_q;
    logic [WORD_W-1:0]  shreg_q;
    logic [1:0]         byte_cnt_q;
    logic [C_IDX_W-1:0] word_idx_q;
    logic [C_IDX_W-1:0] word_idx_d;
    logic [C_TMO_W-1:0] tmo_cnt_q;
    logic               timeout_err_q;

    logic               w_pop;
    logic               w_busy;
    logic               w_idle;
    logic               w_tmo_fire;
    logic               w_valid;

    assign w_pop   = (state_q == S_FETCH) && !rx_empty;
    assign w_busy  = (byte_cnt_q != 2'd0) || (word_idx_q != '0);
    assign w_idle  = (state_q == S_FETCH) && w_busy && rx_empty;
    assign w_valid = !reset && (state_q == S_EMIT);

    generate
        if (WORDS_PER_BLOCK == (1 << C_IDX_W)) begin : g_idx_pow2
            assign word_idx_d = word_idx_q + C_IDX_W'(1);
        end else begin : g_idx_cmp
            assign word_idx_d = (word_idx_q == C_LAST_IDX) ? '0 : word_idx_q + C_IDX_W'(1);
        end

        if (TIMEOUT_CYCLES > 0) begin : g_tmo_on
            assign w_tmo_fire = w_idle && (tmo_cnt_q == C_TMO_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_tmo_off
            assign w_tmo_fire = 1'b0;
        end
    endgenerate

    // A pop always wins over an expiring timeout, so a late byte is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            shreg_q       <= '0;
            byte_cnt_q    <= 2'd0;
            word_idx_q    <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (w_pop) begin
                        shreg_q    <= {shreg_q[WORD_W-BYTE_W-1:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        tmo_cnt_q  <= '0;
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= S_EMIT;
                        end
                    end else if (w_tmo_fire) begin
                        shreg_q       <= '0;
                        byte_cnt_q    <= 2'd0;
                        word_idx_q    <= '0;
                        tmo_cnt_q     <= '0;
                        timeout_err_q <= 1'b1;
                    end else if (w_idle && (TIMEOUT_CYCLES != 0)) begin
                        tmo_cnt_q <= tmo_cnt_q + C_TMO_W'(1);
                    end else begin
                        tmo_cnt_q <= '0;
                    end
                end
                S_EMIT: begin
                    tmo_cnt_q <= '0;
                    if (word_ready) begin
                        state_q    <= S_FETCH;
                        word_idx_q <= word_idx_d;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign rx_read     = !reset && w_pop;
    assign word_valid  = w_valid;
    assign word_data   = w_valid ? shreg_q : '0;
    assign word_last   = w_valid && (word_idx_q == C_LAST_IDX);
    assign word_idx    = reset ? '0 : word_idx_q;
    assign timeout_err = !reset && timeout_err_q;
    assign busy        = !reset && w_busy;

endmodule : uart_word_packer
`default_nettype wire

// File: doc/uart_word_packer.md
# uart_word_packer

Drains received bytes from the UART core's RX FIFO and packs them MSB-first into 32-bit words for the SHA-256 message path. Emits the words on a valid/ready stream and tags the 16th word of each 512-bit block. Sits directly downstream of the UART core: its `rx_read` drives the core's `read_uart`, and its `rx_empty` and `rx_data` come from the core's `rx_empty` and `read_data`. An inter-byte timeout discards partially received blocks so a broken transfer cannot corrupt the next block.

## Interface
- `WORDS_PER_BLOCK`, default 16: words per block; `word_last` marks the final word of each block.
- `TIMEOUT_CYCLES`, default 500000: consecutive idle clock cycles allowed mid-block before the partial block is discarded; 0 disables the timeout.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx_empty`  in  1  RX FIFO empty flag.
- `rx_data`  in  8  RX FIFO head byte; valid whenever `rx_empty`=0.
- `rx_read`  out  1  pops one byte from the RX FIFO on the current edge.
- `word_data`  out  32  packed word; the first received byte lands in bits [31:24].
- `word_valid`  out  1  `word_data` is valid.
- `word_ready`  in  1  consumer accepts the word.
- `word_last`  out  1  high with `word_valid` when `word_idx` = `WORDS_PER_BLOCK`-1.
- `word_idx`  out  $clog2(WORDS_PER_BLOCK)  index of the current word within its block.
- `timeout_err`  out  1  one-cycle pulse when a partial block is discarded.
- `busy`  out  1  high while a block is partially received, i.e. `byte_cnt`≠0 or `word_idx`≠0.

## Operation
- FSM states:
  - `S_FETCH`: collect bytes.
  - `S_EMIT`: present the word and wait for acceptance.
- `S_FETCH` behaviour:
  - `rx_read = (state==S_FETCH) && !rx_empty`. This is combinational on `rx_empty`, so up to one pop per cycle.
  - On a popping edge: `shreg <= {shreg[23:0], rx_data}` and `byte_cnt` increments (2-bit, wraps 3→0).
  - A pop with `byte_cnt`=3 moves the FSM to `S_EMIT`.
- `S_EMIT` behaviour:
  - `word_valid`=1 and `rx_read`=0.
  - `word_data` and `word_last` are held stable until the handshake.
  - On the `word_valid && word_ready` edge: return to `S_FETCH`; `word_idx` increments and wraps from `WORDS_PER_BLOCK`-1 to 0.
- Timeout counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Counts each cycle that is in `S_FETCH`, with `busy`=1 and `rx_empty`=1.
  - Cleared on any pop, in `S_EMIT`, and whenever `busy`=0.
  - When the counter reaches `TIMEOUT_CYCLES`-1 while still idle, the next edge clears `byte_cnt`, `word_idx`, `shreg` and the counter, and sets `timeout_err` for exactly one cycle.
- Priority: a pop beats a timeout in the same cycle. The counter clears and the byte is kept.
- Reset:
  - Returns the FSM to `S_FETCH` and clears all counters and `shreg`.
  - A word held in `S_EMIT` is dropped and not re-presented.
  - All outputs are 0 during and after reset, including `rx_read` (`reset` gates it).

## Timing
- Latency: the edge that pops the 4th byte is followed by `word_valid`=1 in the next cycle.
- Best-case throughput: 4 pop cycles plus 1 emit cycle per word, with `word_ready` tied high.
- The FIFO contract is show-ahead: `rx_data` is sampled on the same edge that `rx_read` pops it.
- Backpressure: `word_ready`=0 stalls indefinitely. No bytes are popped and no timeout counting occurs.
- `word_last` is combinational from `word_idx` and gated by `word_valid`.
- Reset values: `rx_read`=0, `word_data`=0, `word_valid`=0, `word_last`=0, `word_idx`=0, `timeout_err`=0, `busy`=0.

## Structure
- Shared package `sha_uart_pkg`:
  - `BYTE_W`=8 and `WORD_W`=32.
  - The `packer_state_t` enum `{S_FETCH, S_EMIT}`.
  - Used here and later by the SHA result serializer.
- Single module with no sub-modules. The timeout counter is inline; it is too small to split out.
- Wrap-around of `byte_cnt` and `word_idx` uses natural width overflow when `WORDS_PER_BLOCK` is a power of two. Otherwise an explicit compare-and-clear is used.

## Test plan
- Bytes 0x61, 0x62, 0x63, 0x80 on consecutive cycles with `word_ready`=1 → `word_data`=0x61626380 and `word_valid` for one cycle; `word_idx`=0, `word_last`=0.
- Bytes 0x00..0x3F streamed → 16 words, first 0x00010203, last 0x3C3D3E3F with `word_last`=1 at `word_idx`=15; then `word_idx` wraps to 0 and `busy`=0.
- Hold `word_ready`=0 for 5 cycles with FIFO non-empty → `word_data` stable, `rx_read`=0, no timeout; the word is accepted on the 6th cycle and popping resumes next cycle.
- `TIMEOUT_CYCLES`=20; send 3 bytes, then stay idle → `timeout_err` pulses once, 20 cycles after the last pop; then bytes 0xDE, 0xAD, 0xBE, 0xEF → 0xDEADBEEF at `word_idx`=0.
- `TIMEOUT_CYCLES`=20; a byte becomes available in exactly the 20th idle cycle → the byte is popped and `timeout_err` stays 0.
- Assert `reset` in `S_EMIT` with `word_valid`=1 → next cycle all outputs are 0; the following 4 bytes form a fresh word at `word_idx`=0.
